fb_loader: RTL and testbench

FB_LOADER -- requirements
Module: fb_loader

---
 rtl/fb_loader.sv | 133 +++++++++++++
 tb/tb_fb_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_loader.sv
// rtl/fb_loader.sv - program loader, CPU run supervisor and memory dump streamer
module fb_loader #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int DEPTH         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_last,
    input  logic                     cpu_halt,
    input  logic [ADDRESS_WIDTH-1:0] dump_base,
    input  logic [ADDRESS_WIDTH:0]   dump_len,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     own_ram,
    output logic                     cpu_rst,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last,
    output logic [15:0]              run_cycles,
    output logic                     err_ovf
);

    typedef enum logic [2:0] {
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);

    state_t                   state;
    logic [ADDRESS_WIDTH:0]   wptr;
    logic [ADDRESS_WIDTH:0]   count;
    logic [ADDRESS_WIDTH-1:0] rptr;
    logic                     accept;
    logic                     in_room;

    // Loading is only possible in LOAD and never while reset is asserted.
    assign s_ready   = (state == LOAD) && !rst;
    assign accept    = s_valid && s_ready;
    assign in_room   = (wptr < DEPTH_W);
    assign ram_we    = accept && in_room;
    assign ram_wdata = s_data;

    // The CPU owns the RAM and runs out of reset only during RUN.
    assign own_ram   = rst || (state != RUN);
    assign cpu_rst   = rst || (state != RUN);

    // RAM address: write pointer on a real write, read pointer when fetching a dump word, else 0.
    always_comb begin
        ram_addr = '0;
        if (ram_we) begin
            ram_addr = wptr[ADDRESS_WIDTH-1:0];
        end else if (state == DUMP_RD) begin
            ram_addr = rptr;
        end
    end

    // Main sequencer: load, run, dump word by word, then park in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            run_cycles <= '0;
            err_ovf    <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (in_room) begin
                            wptr <= wptr + 1'b1;
                        end else begin
                            err_ovf <= 1'b1;
                        end
                        if (s_last) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (cpu_halt) begin
                        rptr  <= dump_base;
                        count <= dump_len;
                        state <= (dump_len == '0) ? DONE : DUMP_RD;
                    end
                end
                DUMP_RD: begin
                    state <= DUMP_CAP;
                end
                DUMP_CAP: begin
                    m_data  <= ram_rdata;
                    m_last  <= (count == (ADDRESS_WIDTH + 1)'(1));
                    m_valid <= 1'b1;
                    state   <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        rptr    <= rptr + 1'b1;
                        count   <= count - 1'b1;
                        state   <= (count > (ADDRESS_WIDTH + 1)'(1)) ? DUMP_RD : DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_loader.sv
// tb/tb_fb_loader.sv - randomized self-checking bench for fb_loader
module tb_fb_loader;

    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          cpu_halt;
    logic [AW-1:0] dump_base;
    logic [AW:0]   dump_len;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          own_ram;
    logic          cpu_rst;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   run_cycles;
    logic          err_ovf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem[DEPTH];
    logic [DW-1:0] exp_mem[DEPTH];
    logic [DW-1:0] prog[$];
    int            wa_q[$];
    int            wd_q[$];

    fb_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cpu_halt(cpu_halt), .dump_base(dump_base), .dump_len(dump_len),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .own_ram(own_ram), .cpu_rst(cpu_rst),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .run_cycles(run_cycles), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Write log observed on the RAM port
    always @(negedge clk) begin
        if (ram_we) begin
            wa_q.push_back(int'(ram_addr));
            wd_q.push_back(int'(ram_wdata));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; s_valid = 0; s_last = 0; cpu_halt = 0; m_ready = 0;
        repeat (3) tick();
        rst = 0;
    endtask

    // Stream prog[] into the loader; gap_mode 0 = idle every other cycle, 1 = random idles
    task automatic load_prog(input int gap_mode);
        int n;
        n = prog.size();
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < n; i++) begin
            if ((gap_mode == 0 && i > 0) || (gap_mode == 1 && $urandom_range(0, 2) == 0)) begin
                s_valid = 0; s_data = DW'($urandom); s_last = 1'($urandom); cpu_halt = 1'($urandom);
                tick();
            end
            s_valid = 1; s_data = prog[i]; s_last = (i == n - 1); cpu_halt = 1'($urandom);
            tick();
            if (i < DEPTH) exp_mem[i] = prog[i];
        end
        s_valid = 0; s_last = 0; cpu_halt = 0;
    endtask

    task automatic verify_load(input string name);
        int n;
        int nw;
        n  = prog.size();
        nw = (n > DEPTH) ? DEPTH : n;
        checks++;
        if (wa_q.size() !== nw) begin
            errors++; $display("FAIL %s write_count got %0d exp %0d", name, wa_q.size(), nw);
        end
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== i || wd_q[i] !== int'(prog[i])) begin
                errors++;
                $display("FAIL %s write[%0d] got addr %0d data %0h exp addr %0d data %0h",
                         name, i, wa_q[i], wd_q[i], i, prog[i]);
            end
        end
        checks++;
        if (err_ovf !== (n > DEPTH)) begin
            errors++; $display("FAIL %s err_ovf got %0b exp %0b", name, err_ovf, (n > DEPTH));
        end
        checks++;
        if (cpu_rst !== 1'b0 || own_ram !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s run_entry got cpu_rst %0b own_ram %0b s_ready %0b exp 0 0 0",
                     name, cpu_rst, own_ram, s_ready);
        end
    endtask

    // Run for run_n cycles, halt, and collect the dump; mode 0 ready, 1 random, 2 stall 5 then ready
    task automatic run_and_dump(input string name, input int run_n, input int base, input int len,
                                input int mode);
        logic [DW-1:0] got_d[$];
        logic          got_l[$];
        bit            hold;
        logic [DW-1:0] hd;
        logic          hl;
        int            stalls;
        int            cyc;
        int            idx;
        hold = 0; stalls = 0; cyc = 0; hd = '0; hl = 0;
        cpu_halt = 0;
        repeat (run_n - 1) tick();
        cpu_halt = 1; dump_base = AW'(base); dump_len = (AW + 1)'(len);
        tick();
        cpu_halt = 0; dump_base = AW'($urandom); dump_len = (AW + 1)'($urandom);
        checks++;
        if (run_cycles !== 16'(run_n)) begin
            errors++; $display("FAIL %s run_cycles got %0d exp %0d", name, run_cycles, run_n);
        end
        while (got_d.size() < len && cyc < 20 * len + 20) begin
            m_ready = (mode == 2) ? (stalls >= 5) : (mode == 1) ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl) begin
                    errors++;
                    $display("FAIL %s stall_stable got v %0b d %0h l %0b exp v 1 d %0h l %0b",
                             name, m_valid, m_data, m_last, hd, hl);
                end
            end
            hold = 0;
            if (m_valid === 1'b1) begin
                if (m_ready) begin
                    got_d.push_back(m_data);
                    got_l.push_back(m_last);
                end else begin
                    hold = 1; hd = m_data; hl = m_last; stalls++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        m_ready = 0;
        checks++;
        if (got_d.size() !== len) begin
            errors++; $display("FAIL %s dump_count got %0d exp %0d", name, got_d.size(), len);
        end
        for (int i = 0; i < len && i < got_d.size(); i++) begin
            idx = (base + i) % DEPTH;
            checks++;
            if (got_d[i] !== exp_mem[idx] || got_l[i] !== (i == len - 1)) begin
                errors++;
                $display("FAIL %s dump[%0d] got data %0h last %0b exp data %0h last %0b",
                         name, i, got_d[i], got_l[i], exp_mem[idx], (i == len - 1));
            end
        end
        m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            cpu_halt = 1'($urandom); s_valid = 1'($urandom);
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b0 || own_ram !== 1'b1 || cpu_rst !== 1'b1 ||
                ram_we !== 1'b0 || ram_addr !== '0) begin
                errors++;
                $display("FAIL %s done got mv %0b sr %0b own %0b crst %0b we %0b addr %0d exp 0 0 1 1 0 0",
                         name, m_valid, s_ready, own_ram, cpu_rst, ram_we, ram_addr);
            end
            @(posedge clk);
            #1;
        end
        cpu_halt = 0; s_valid = 0; m_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; s_valid = 1; s_data = '1; s_last = 1; cpu_halt = 1; m_ready = 1;
        repeat (10) tick();
        checks++;
        if (cpu_rst !== 1 || own_ram !== 1 || s_ready !== 0 || m_valid !== 0 || run_cycles !== 0 ||
            err_ovf !== 0 || ram_we !== 0 || m_last !== 0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset got crst %0b own %0b sr %0b mv %0b rc %0d ovf %0b we %0b ml %0b md %0h",
                     cpu_rst, own_ram, s_ready, m_valid, run_cycles, err_ovf, ram_we, m_last, m_data);
        end
        s_valid = 0; s_last = 0; cpu_halt = 0; m_ready = 0;
        rst = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release s_ready got %0b exp 1", s_ready);
        end
    endtask

    task automatic test_load_basic();
        do_reset();
        prog = '{10'h032, 10'h0B3, 10'h074};
        load_prog(0);
        verify_load("load_basic");
        run_and_dump("load_basic_dump", $urandom_range(1, 30), 0, 3, 1);
    endtask

    task automatic test_overflow_dump();
        do_reset();
        prog.delete();
        for (int i = 0; i < 66; i++) prog.push_back(DW'($urandom));
        prog[52] = 10'h00F;
        load_prog(1);
        verify_load("overflow");
        run_and_dump("dump_single", 20, 52, 1, 2);
    endtask

    task automatic test_wrap();
        do_reset();
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(DW'($urandom));
        load_prog(1);
        verify_load("wrap_load");
        run_and_dump("wrap", $urandom_range(1, 10), 63, 2, 1);
    endtask

    task automatic test_empty();
        do_reset();
        prog = '{DW'($urandom)};
        load_prog(1);
        verify_load("empty_load");
        run_and_dump("empty", 5, 17, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < $urandom_range(1, 70); i++) prog.push_back(DW'($urandom));
            load_prog(1);
            verify_load("rand_load");
            run_and_dump("rand_dump", $urandom_range(1, 40), $urandom_range(0, 63),
                         $urandom_range(1, 64), 1);
        end
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        do_reset();
        prog.delete();
        for (int i = 0; i < 10; i++) prog.push_back(DW'($urandom));
        load_prog(1);
        m_ready = 0; cpu_halt = 1; dump_base = 0; dump_len = 5;
        tick();
        cpu_halt = 0;
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL mid_dump_reach m_valid got %0b exp 1", m_valid);
        end
        rst = 1;
        tick();
        checks++;
        if (m_valid !== 0 || s_ready !== 0 || own_ram !== 1 || cpu_rst !== 1) begin
            errors++;
            $display("FAIL mid_dump_rst got mv %0b sr %0b own %0b crst %0b exp 0 0 1 1",
                     m_valid, s_ready, own_ram, cpu_rst);
        end
        rst = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL mid_dump_release s_ready got %0b exp 1", s_ready);
        end
        prog = '{DW'($urandom), DW'($urandom), DW'($urandom)};
        load_prog(1);
        verify_load("reload");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        ram_rdata = '0; dump_base = '0; dump_len = '0; s_data = '0;
        rst = 1; s_valid = 0; s_last = 0; cpu_halt = 0; m_ready = 0;
        test_reset();
        test_load_basic();
        test_overflow_dump();
        test_wrap();
        test_empty();
        test_random();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
